// File: rtl/multi_clk_divider.sv
// Purpose : NUM_CH programmable clock dividers, each with a matching period-start strobe.
//           Ratio changes land only on period boundaries, so outputs never show runt pulses.
// Latency : ch_en rise -> clk_div_out/ce_out high at the same edge that enters RUN;
//           all outputs are registered.
// Backpr. : cfg_ready = ~pend[cfg_ch]. A channel with an update still pending refuses a
//           second write; writes to other channels are unaffected.
//
// Ports:
//   SYS_CLK_IN  - system clock, all logic on the rising edge
//   SYS_RST_IN  - synchronous active-high reset
//   ch_en       - per-channel run enable
//   cfg_valid / cfg_ready / cfg_ch / cfg_div - ratio-write handshake (ratios 0,1 clamp to 2)
//   clk_div_out - divided clock per channel
//   ce_out      - one-cycle strobe at each period start
//   pend_out    - ratio update waiting for the next period boundary
//   sync_start  - only when MULTI_CLK_DIVIDER_SYNC_START_EN is defined: restarts the
//                 period of every running channel on the same edge
module multi_clk_divider #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              SYS_CLK_IN,
    input  logic              SYS_RST_IN,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
`ifdef MULTI_CLK_DIVIDER_SYNC_START_EN
    input  logic              sync_start,
`endif
    output logic [NUM_CH-1:0] clk_div_out,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] pend_out
);

    logic [NUM_CH-1:0] pend;
    logic [DIV_W-1:0]  cfg_div_eff;
    logic              cfg_wr;
    logic              restart_all;

    // Ratios below 2 cannot form a period with both a high and a low phase.
    assign cfg_div_eff = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;

    // Out-of-range channel numbers read as ready; such writes hit no channel.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend[i];
            end
        end
    end

    assign cfg_wr   = cfg_valid & cfg_ready;
    assign pend_out = pend;

`ifdef MULTI_CLK_DIVIDER_SYNC_START_EN
    assign restart_all = sync_start;
`else
    assign restart_all = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

        state_t           state;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] ratio;
        logic [DIV_W-1:0] shadow;
        logic             pend_r;
        logic             clk_r;
        logic             ce_r;
        logic             wr_hit;
        logic             restart;
        logic [DIV_W-1:0] cnt_inc;

        assign wr_hit  = cfg_wr && (cfg_ch == CH_W'(g));
        // Period boundary: natural wrap or a forced common restart.
        assign restart = (cnt == ratio - DIV_W'(1)) || restart_all;
        assign cnt_inc = cnt + DIV_W'(1);

        always_ff @(posedge SYS_CLK_IN) begin
            if (SYS_RST_IN) begin
                state  <= IDLE;
                cnt    <= '0;
                ratio  <= DIV_W'(DEFAULT_DIV);
                shadow <= DIV_W'(DEFAULT_DIV);
                pend_r <= 1'b0;
                clk_r  <= 1'b0;
                ce_r   <= 1'b0;
            end else if (state == IDLE) begin
                // Nothing is being generated, so a new ratio can take effect at once.
                if (wr_hit) begin
                    ratio <= cfg_div_eff;
                end
                cnt <= '0;
                if (ch_en[g]) begin
                    state <= RUN;
                    clk_r <= 1'b1;
                    ce_r  <= 1'b1;
                end else begin
                    clk_r <= 1'b0;
                    ce_r  <= 1'b0;
                end
            end else if (!ch_en[g]) begin
                // Stop: drop the partial period, settle any outstanding ratio.
                state  <= IDLE;
                cnt    <= '0;
                clk_r  <= 1'b0;
                ce_r   <= 1'b0;
                pend_r <= 1'b0;
                if (wr_hit) begin
                    ratio <= cfg_div_eff;
                end else if (pend_r) begin
                    ratio <= shadow;
                end
            end else if (restart) begin
                cnt   <= '0;
                clk_r <= 1'b1;
                ce_r  <= 1'b1;
                // Uses pend as it stood before this edge: a write landing now waits
                // for the following boundary. wr_hit implies pend_r was 0.
                if (pend_r) begin
                    ratio  <= shadow;
                    pend_r <= 1'b0;
                end
                if (wr_hit) begin
                    shadow <= cfg_div_eff;
                    pend_r <= 1'b1;
                end
            end else begin
                cnt   <= cnt_inc;
                ce_r  <= 1'b0;
                // High for the first floor(N/2) counts of the period.
                clk_r <= (cnt_inc < (ratio >> 1));
                if (wr_hit) begin
                    shadow <= cfg_div_eff;
                    pend_r <= 1'b1;
                end
            end
        end

        assign pend[g]        = pend_r;
        assign clk_div_out[g] = clk_r;
        assign ce_out[g]      = ce_r;
    end

endmodule

// File: tb/tb_multi_clk_divider.sv
`timescale 1ns/1ps
module tb_multi_clk_divider;

    logic       clk;
    logic       rst;
    logic [3:0] ch_en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       sync_start;
    logic [3:0] clk_div_out;
    logic [3:0] ce_out;
    logic [3:0] pend_out;

    multi_clk_divider #(.NUM_CH(4), .DIV_W(8), .DEFAULT_DIV(2)) dut (
        .SYS_CLK_IN (clk),
        .SYS_RST_IN (rst),
        .ch_en      (ch_en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
`ifdef MULTI_CLK_DIVIDER_SYNC_START_EN
        .sync_start (sync_start),
`endif
        .clk_div_out(clk_div_out),
        .ce_out     (ce_out),
        .pend_out   (pend_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] en;
        logic       v;
        logic [1:0] ch;
        logic [7:0] div;
        logic       sync;
        logic [3:0] eclk;
        logic [3:0] ece;
        logic [3:0] epend;
        logic       erdy;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] eclk;
        logic [3:0] ece;
        logic [3:0] epend;
        logic       erdy;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(input int r, input int en, input int v, input int ch,
                                input int div, input int s, input int ec, input int ece,
                                input int ep, input int er);
        vec_t t;
        t.rst   = r[0];
        t.en    = en[3:0];
        t.v     = v[0];
        t.ch    = ch[1:0];
        t.div   = div[7:0];
        t.sync  = s[0];
        t.eclk  = ec[3:0];
        t.ece   = ece[3:0];
        t.epend = ep[3:0];
        t.erdy  = er[0];
        vecs.push_back(t);
    endfunction

    task automatic check(input string nm, input int idx, input logic [3:0] act,
                         input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   ce_cnt;
        int   hi_cnt;
        int   first_ce;
        int   second_ce;

        rst = 1'b1; ch_en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; sync_start = 1'b0;

        // rst en  v ch div sync | clk ce pend rdy
        // Reset, then ch0 at the default ratio 2.
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0,  0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0,  0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        // ch1 written to 5 while idle, then run two periods.
        add(0, 0, 1, 1, 5, 0,  0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            add(0, 2, 0, 1, 0, 0,  2, 2, 0, 1);
            add(0, 2, 0, 1, 0, 0,  2, 0, 0, 1);
            add(0, 2, 0, 1, 0, 0,  0, 0, 0, 1);
            add(0, 2, 0, 1, 0, 0,  0, 0, 0, 1);
            add(0, 2, 0, 1, 0, 0,  0, 0, 0, 1);
        end
        add(0, 0, 0, 1, 0, 0,  0, 0, 0, 1);
        // ch0 at 4, update to 7 mid-period; second write to ch0 blocked, ch2 write passes.
        add(0, 0, 1, 0, 4, 0,  0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 0, 0, 1);
        add(0, 1, 1, 0, 7, 0,  0, 0, 1, 0);
        add(0, 1, 1, 2, 3, 0,  0, 0, 1, 1);
        add(0, 1, 1, 0, 9, 0,  1, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 0, 0, 1);
        for (int k = 0; k < 4; k++) add(0, 1, 0, 0, 0, 0,  0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        // ch2 at 3, write of 6 exactly on the wrap edge: one more 3-period, then 6.
        add(0, 4, 0, 2, 0, 0,  4, 4, 0, 1);
        add(0, 4, 0, 2, 0, 0,  0, 0, 0, 1);
        add(0, 4, 0, 2, 0, 0,  0, 0, 0, 1);
        add(0, 4, 1, 2, 6, 0,  4, 4, 4, 0);
        add(0, 4, 0, 2, 0, 0,  0, 0, 4, 0);
        add(0, 4, 0, 2, 0, 0,  0, 0, 4, 0);
        add(0, 4, 0, 2, 0, 0,  4, 4, 0, 1);
        add(0, 4, 0, 2, 0, 0,  4, 0, 0, 1);
        add(0, 4, 0, 2, 0, 0,  4, 0, 0, 1);
        for (int k = 0; k < 3; k++) add(0, 4, 0, 2, 0, 0,  0, 0, 0, 1);
        add(0, 4, 0, 2, 0, 0,  4, 4, 0, 1);
        // Ratio 0 clamps to 2.
        add(0, 0, 0, 2, 0, 0,  0, 0, 0, 1);
        add(0, 0, 1, 2, 0, 0,  0, 0, 0, 1);
        add(0, 4, 0, 2, 0, 0,  4, 4, 0, 1);
        add(0, 4, 0, 2, 0, 0,  0, 0, 0, 1);
        add(0, 4, 0, 2, 0, 0,  4, 4, 0, 1);
        add(0, 0, 0, 2, 0, 0,  0, 0, 0, 1);
        // ch3 at 9 with a pending update; reset mid-period, then back at ratio 2.
        add(0, 0, 1, 3, 9, 0,  0, 0, 0, 1);
        add(0, 8, 0, 3, 0, 0,  8, 8, 0, 1);
        add(0, 8, 0, 3, 0, 0,  8, 0, 0, 1);
        add(0, 8, 0, 3, 0, 0,  8, 0, 0, 1);
        add(0, 8, 1, 3, 5, 0,  8, 0, 8, 0);
        add(1, 8, 0, 3, 0, 0,  0, 0, 0, 1);
        add(0, 8, 0, 3, 0, 0,  8, 8, 0, 1);
        add(0, 8, 0, 3, 0, 0,  0, 0, 0, 1);
        add(0, 8, 0, 3, 0, 0,  8, 8, 0, 1);
        // ch1 (now 2 after reset): enable drop while high gives 0, no strobe.
        add(0, 2, 0, 1, 0, 0,  2, 2, 0, 1);
        add(0, 0, 0, 1, 0, 0,  0, 0, 0, 1);
        add(0, 2, 0, 1, 0, 0,  2, 2, 0, 1);
        add(0, 2, 0, 1, 0, 0,  0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0,  0, 0, 0, 1);
        // ch0: pending update applied when enable falls.
        add(0, 1, 0, 0, 0, 0,  1, 1, 0, 1);
        add(0, 1, 1, 0, 3, 0,  0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0,  0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0,  0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
`ifdef MULTI_CLK_DIVIDER_SYNC_START_EN
        // ch0 at 3, ch1 at 6 started out of phase; sync_start aligns them.
        add(0, 0, 1, 1, 6, 0,  0, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0,  1, 1, 0, 1);
        add(0, 1, 0, 1, 0, 0,  0, 0, 0, 1);
        add(0, 3, 0, 1, 0, 0,  2, 2, 0, 1);
        add(0, 3, 0, 1, 0, 0,  3, 1, 0, 1);
        add(0, 3, 0, 1, 0, 1,  3, 3, 0, 1);
        add(0, 3, 0, 1, 0, 0,  2, 0, 0, 1);
        add(0, 3, 0, 1, 0, 0,  2, 0, 0, 1);
        add(0, 3, 0, 1, 0, 0,  1, 1, 0, 1);
        add(0, 3, 0, 1, 0, 0,  0, 0, 0, 1);
        add(0, 3, 0, 1, 0, 0,  0, 0, 0, 1);
        add(0, 3, 0, 1, 0, 0,  3, 3, 0, 1);
        add(0, 0, 0, 1, 0, 0,  0, 0, 0, 1);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            rst        = vecs[i].rst;
            ch_en      = vecs[i].en;
            cfg_valid  = vecs[i].v;
            cfg_ch     = vecs[i].ch;
            cfg_div    = vecs[i].div;
            sync_start = vecs[i].sync;
            exp_q.push_back('{i, vecs[i].eclk, vecs[i].ece, vecs[i].epend, vecs[i].erdy});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check("clk_div_out", e.idx, clk_div_out, e.eclk);
            check("ce_out", e.idx, ce_out, e.ece);
            check("pend_out", e.idx, pend_out, e.epend);
            check("cfg_ready", e.idx, {3'b000, cfg_ready}, {3'b000, e.erdy});
        end

        // Maximum ratio 255 on ch0: period 255, high time 127.
        rst = 1'b0; ch_en = '0; sync_start = 1'b0;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd255;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        ch_en = 4'b0001;
        ce_cnt = 0; hi_cnt = 0; first_ce = -1; second_ce = -1;
        for (int c = 1; c <= 510; c++) begin
            @(posedge clk);
            #1;
            if (ce_out[0]) begin
                ce_cnt++;
                if (first_ce < 0) first_ce = c;
                else if (second_ce < 0) second_ce = c;
            end
            if (clk_div_out[0]) hi_cnt++;
        end
        ch_en = '0;
        n_cmp++;
        if (ce_cnt != 2) begin
            n_bad++;
            $display("FAIL max_ratio_ce_count: got %0d expected 2", ce_cnt);
        end
        n_cmp++;
        if (first_ce != 1) begin
            n_bad++;
            $display("FAIL max_ratio_first_ce: got cycle %0d expected 1", first_ce);
        end
        n_cmp++;
        if (second_ce - first_ce != 255) begin
            n_bad++;
            $display("FAIL max_ratio_period: got %0d expected 255", second_ce - first_ce);
        end
        n_cmp++;
        if (hi_cnt != 254) begin
            n_bad++;
            $display("FAIL max_ratio_high_cycles: got %0d expected 254", hi_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
